// File: rtl/chunked_add_sub_if.sv
// Valid/ready operand port and valid/ready result port of the chunked add/sub unit.
interface chunked_add_sub_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] s;
  logic         cout;
  logic         ovf;
  logic         zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf, zero
  );
endinterface

// File: rtl/chunked_add_sub.sv
// Time-multiplexed N-bit adder/subtractor: W bits per cycle through a carry register.
// state | meaning
// IDLE  | ready for an operand pair, result registers hold last value
// RUN   | adding chunk cnt, carry flop links chunks
// DONE  | result and flags valid, waiting for out_ready
module chunked_add_sub #(
  parameter int N = 8,
  parameter int W = 2
) (
  input logic              clk,
  input logic              rst_n,
  chunked_add_sub_if.slave bus
);
  localparam int K  = N / W;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  if (N % W != 0) begin : g_bad_width
    $error("chunked_add_sub: N must be a multiple of W");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          carry;
  logic [N-1:0]  a_reg, b_reg, s_reg, s_new;
  logic          cout_reg, ovf_reg, zero_reg, out_valid_reg;
  logic [W-1:0]  a_ch, b_ch;
  logic [W:0]    chunk_sum;
  logic          last;

  assign last = (cnt == CW'(K - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = RUN;
      RUN:     if (last)         state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = (state == IDLE);
  end

  // Chunk select and writeback through a constant-index loop so each slice is a plain mux.
  always_comb begin
    a_ch  = '0;
    b_ch  = '0;
    s_new = s_reg;
    for (int k = 0; k < K; k++) begin
      if (int'(cnt) == k) begin
        a_ch = a_reg[k*W +: W];
        b_ch = b_reg[k*W +: W];
      end
    end
    chunk_sum = {1'b0, a_ch} + {1'b0, b_ch} + {{W{1'b0}}, carry};
    for (int k = 0; k < K; k++) begin
      if (int'(cnt) == k) s_new[k*W +: W] = chunk_sum[W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      carry         <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      s_reg         <= '0;
      cout_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
      zero_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg <= bus.a;
            b_reg <= bus.b ^ {N{bus.sub}};
            carry <= bus.cin ^ bus.sub;
            cnt   <= '0;
          end
        end
        RUN: begin
          s_reg <= s_new;
          carry <= chunk_sum[W];
          if (last) begin
            cout_reg      <= chunk_sum[W];
            ovf_reg       <= a_reg[N-1] ^ b_reg[N-1] ^ s_new[N-1] ^ chunk_sum[W];
            zero_reg      <= (s_new == '0);
            out_valid_reg <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) out_valid_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.s         = s_reg;
  assign bus.cout      = cout_reg;
  assign bus.ovf       = ovf_reg;
  assign bus.zero      = zero_reg;
  assign bus.out_valid = out_valid_reg;
endmodule

// File: tb/tb_chunked_add_sub.sv
// Directed vector bench for chunked_add_sub with N=8, W=2 (four chunks per operation).
module tb_chunked_add_sub;
  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   lat;

  always #5 clk = ~clk;

  chunked_add_sub_if #(.N(8)) bus ();
  chunked_add_sub #(.N(8), .W(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [7:0] a, b;
    logic       cin, sub;
    logic [7:0] s;
    logic       cout, ovf, zero;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Presents operands for one edge and returns edges from accept until out_valid.
  task automatic do_op(input logic [7:0] a, b, input logic cin, sub, output int l);
    check("in_ready_before_op", {31'b0, bus.in_ready}, 32'd1);
    bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    l = 0;
    while (!bus.out_valid && l < 20) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("out_valid_after_consume", {31'b0, bus.out_valid}, 32'd0);
    check("in_ready_after_consume", {31'b0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    vecs[0] = '{8'h3C, 8'h25, 1'b0, 1'b0, 8'h61, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{8'h07, 8'h05, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{8'h33, 8'h33, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    check("rst_s", {24'b0, bus.s}, 32'h0);
    check("rst_flags", {28'b0, bus.cout, bus.ovf, bus.zero, bus.out_valid}, 32'h0);
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat);
      check($sformatf("v%0d_latency", i), lat, 32'd4);
      check($sformatf("v%0d_s", i), {24'b0, bus.s}, {24'b0, vecs[i].s});
      check($sformatf("v%0d_cout", i), {31'b0, bus.cout}, {31'b0, vecs[i].cout});
      check($sformatf("v%0d_ovf", i), {31'b0, bus.ovf}, {31'b0, vecs[i].ovf});
      check($sformatf("v%0d_zero", i), {31'b0, bus.zero}, {31'b0, vecs[i].zero});
      consume();
    end

    // Backpressure with new operands pending: nothing may be accepted until the result is taken.
    do_op(8'h12, 8'h34, 1'b0, 1'b0, lat);
    check("bp_latency", lat, 32'd4);
    bus.a = 8'hAA; bus.b = 8'h11; bus.cin = 1'b0; bus.sub = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_s_stable", {24'b0, bus.s}, 32'h46);
      check("bp_flags_stable", {28'b0, bus.cout, bus.ovf, bus.zero, bus.out_valid}, 32'h1);
      check("bp_in_ready_low", {31'b0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp_out_valid_drop", {31'b0, bus.out_valid}, 32'd0);
    check("bp_in_ready_rise", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("pend_latency", lat, 32'd4);
    check("pend_s", {24'b0, bus.s}, 32'h99);
    check("pend_cout", {31'b0, bus.cout}, 32'd1);
    check("pend_ovf", {31'b0, bus.ovf}, 32'd0);
    consume();

    // Reset two cycles into RUN aborts the operation.
    bus.a = 8'hF0; bus.b = 8'h0F; bus.cin = 1'b1; bus.sub = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("abort_s", {24'b0, bus.s}, 32'h0);
    check("abort_flags", {28'b0, bus.cout, bus.ovf, bus.zero, bus.out_valid}, 32'h0);
    check("abort_in_ready", {31'b0, bus.in_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_valid", {31'b0, bus.out_valid}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_no_valid", {31'b0, bus.out_valid}, 32'd0);
    do_op(8'h10, 8'h20, 1'b0, 1'b0, lat);
    check("post_rst_latency", lat, 32'd4);
    check("post_rst_s", {24'b0, bus.s}, 32'h30);
    check("post_rst_flags", {29'b0, bus.cout, bus.ovf, bus.zero}, 32'h0);
    consume();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/chunked_add_sub.md
# chunked_add_sub

- Multi-cycle, parametrised adder/subtractor.
- Processes an N-bit operand pair W bits per clock, carrying between chunks through a carry register. This is the time-multiplexed successor of the combinational ripple-carry chain.
- Sits behind a valid/ready input port and a valid/ready result port. Datapath units that trade latency for area use it as their shared add/sub resource.
- Reports sum, carry/borrow-out, signed overflow and zero flags.

## Interface

- N, default 8: operand and result width.
- W, default 2: bits processed per cycle. N % W != 0 is an elaboration error. K = N/W chunks; W = N gives K = 1.
- clk  in  1  single clock; all flops update on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept; high only in IDLE.
- a  in  N  operand A (unsigned or two's complement).
- b  in  N  operand B.
- cin  in  1  carry-in (add) or borrow-in (sub).
- sub  in  1  0 = a+b+cin, 1 = a-b-cin.
- out_valid  out  1  result registers valid.
- out_ready  in  1  consumer takes result.
- s  out  N  result.
- cout  out  1  add: carry-out; sub: 1 = no borrow (a >= b+cin unsigned).
- ovf  out  1  signed two's-complement overflow.
- zero  out  1  s == 0.

## Operation

- **States:** IDLE, RUN, DONE. The state register and a chunk counter of width max(1, clog2(K)) are the only control state.
- **IDLE:** in_ready = 1.
  - On in_valid & in_ready: latch a, b_eff = b ^ {N{sub}}, carry = cin ^ sub. Clear counter; go to RUN.
  - Subtraction is therefore a + ~b + 1 - cin.
- **RUN:** each cycle, chunk k = counter:
  - {c, sum_k} = a[kW +: W] + b_eff[kW +: W] + carry.
  - sum_k is written to s[kW +: W], and carry <= c.
  - If counter == K-1: go to DONE. Otherwise counter increments.
- **RUN → DONE update:**
  - cout <= final carry.
  - ovf <= a[N-1] ^ b_eff[N-1] ^ s_new[N-1] ^ cout_new, i.e. carry into the MSB xor carry out of it.
  - zero <= (s_new == 0).
  - out_valid <= 1.
- **DONE:** s, cout, ovf, zero and out_valid are held stable. On out_ready: out_valid <= 0, go to IDLE.
- **Inputs outside IDLE:** in_valid is ignored in RUN and DONE, and operand inputs may change freely there.
- **Register contents:** s, cout, ovf, zero keep their last values in IDLE. Higher chunks of s are stale while RUN is in progress; consumers qualify with out_valid only.
- **Widths:** the per-chunk adder is W+1 bits wide. No carry is lost between chunks. Wrap-around mod 2^N is reported through cout.

## Timing

- **Reset:** asynchronous on rst_n low.
  - state = IDLE, counter = 0, carry = 0.
  - s = 0, cout = 0, ovf = 0, zero = 0, out_valid = 0.
  - in_ready reads 1.
  - Reset mid-RUN or mid-DONE aborts the transaction with no output. The first edge after rst_n rises may accept a new operand pair.
- **Latency:** accepted on edge E0; out_valid high after edge E0+K.
- **Handshake:**
  - A result is consumed on the first edge where out_valid & out_ready.
  - in_ready rises after that edge.
  - Minimum initiation interval is K+2 cycles (accept, K RUN cycles, consume, re-accept in IDLE).
- **Backpressure:** out_ready may be low indefinitely in DONE with no change to outputs. out_ready high before out_valid has no effect.
- **Combinational paths:** in_ready is decoded from state only. There are no paths from in_valid or out_ready to outputs.
- **Critical path:** one W-bit add plus the carry register.

## Test plan

Directed scenarios with N=8, W=2 (K=4):

- **Add, with latency check:** a=0x3C, b=0x25, cin=0, sub=0 → s=0x61, cout=0, ovf=0, zero=0. out_valid rises exactly 4 edges after accept.
- **Unsigned wrap:** add a=0xFF, b=0x01, cin=0 → s=0x00, cout=1, zero=1, ovf=0.
- **Signed overflow:**
  - Add a=0x7F, b=0x01 → s=0x80, ovf=1, cout=0.
  - Sub a=0x80, b=0x01, cin=0 → s=0x7F, ovf=1, cout=1.
- **Borrow:** sub a=0x05, b=0x07, cin=0 → s=0xFE, cout=0, ovf=0. Then sub a=0x07, b=0x05, cin=1 → s=0x01, cout=1.
- **Backpressure and ignored input:**
  - Hold out_ready=0 for 5 cycles after out_valid while driving in_valid=1 with new operands → s/flags stable, in_ready=0, nothing accepted.
  - Raise out_ready → out_valid drops next edge, in_ready=1, and the pending operands are then accepted.
- **Reset abort:**
  - Assert rst_n=0 asynchronously 2 cycles into RUN → all outputs 0 immediately, no out_valid.
  - After release, a=0x10, b=0x20 add → s=0x30 with 4-cycle latency.
